// File: rtl/seq_sum_pkg.sv
// Shared types and sizing helpers for the seq_sum serial multi-operand adder.
package seq_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Accumulator width wide enough that the full sum of all channels never wraps.
    function automatic int acc_w(input int width, input int channels);
        return width + $clog2(channels) + 1;
    endfunction

endpackage

// File: rtl/seq_sum_fmt.sv
// Reduces the full-width accumulator to the OUT_W-bit result plus overflow flag.
// Build option: define SEQ_SUM_SATURATE_EN to clamp on overflow instead of wrapping.
module seq_sum_fmt
    import seq_sum_pkg::*;
#(
    parameter int ACC_W = 6,
    parameter int OUT_W = 5
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] sum,
    output logic             ovf
);

    logic [OUT_W-1:0] wrap;

    generate
        if (OUT_W < ACC_W) begin : g_narrow
            assign ovf  = |acc[ACC_W-1:OUT_W];
            assign wrap = acc[OUT_W-1:0];
        end else begin : g_wide
            assign ovf  = 1'b0;
            assign wrap = OUT_W'(acc);
        end
    endgenerate

`ifdef SEQ_SUM_SATURATE_EN
    assign sum = ovf ? '1 : wrap;
`else
    assign sum = wrap;
`endif

endmodule

// File: rtl/seq_sum.sv
// Sequential multi-operand unsigned adder: captures CHANNELS operands, adds one per clock.
// Wrap vs. saturate on overflow is selected by SEQ_SUM_SATURATE_EN (see seq_sum_fmt).
module seq_sum
    import seq_sum_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int OUT_W    = WIDTH + $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          sum,
    output logic                      ovf
);

    localparam int ACC_W = acc_w(WIDTH, CHANNELS);
    localparam int IDX_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [OUT_W-1:0]          sum_q, sum_d;
    logic                      ovf_q, ovf_d;

    logic [WIDTH-1:0]          operand;
    logic [ACC_W-1:0]          acc_next;
    logic [OUT_W-1:0]          fmt_sum;
    logic                      fmt_ovf;

    always_comb begin
        operand = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                operand = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    assign acc_next = acc_q + ACC_W'(operand);

    // Formatting works on the post-add value so the result registers on the final ACCUM edge.
    seq_sum_fmt #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_fmt (
        .acc (acc_next),
        .sum (fmt_sum),
        .ovf (fmt_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    idx_d   = '0;
                    sum_d   = fmt_sum;
                    ovf_d   = fmt_ovf;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seq_sum.md
Name: seq_sum

Overview:
Parametrised sequential multi-operand unsigned adder. It captures CHANNELS operands of WIDTH bits in one valid/ready handshake, then accumulates them serially, one channel per clock. It presents an OUT_W-bit sum with an overflow flag through a valid/ready output handshake. It is the next-generation switch-bank summer for the LED/seven-segment display path and is driven by the board clock.

Parameters:
WIDTH, 4, bits per operand
CHANNELS, 2, number of operands summed per transaction (>=2)
OUT_W, WIDTH+$clog2(CHANNELS), result width; smaller values permit overflow

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept a bundle
in_data  input  CHANNELS*WIDTH  operands; channel i at [i*WIDTH +: WIDTH]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  OUT_W  result (wrapped or saturated, see Optional Feature)
ovf  output  1  true sum exceeded 2^OUT_W-1

Behaviour:
- Reset (reset=0, async): state=IDLE, acc=0, idx=0, in_ready=1, out_valid=0, sum=0, ovf=0; captured operands cleared.
- States: IDLE, ACCUM, DONE (enum in package).
- IDLE: in_ready=1. On an edge with in_valid=1, register in_data, clear acc/ovf, set idx=0, and go to ACCUM. If in_valid=0, stay in IDLE.
- ACCUM: in_ready=0. Each edge adds operand[idx] to acc and increments idx. When idx==CHANNELS-1 is added, go to DONE.
- Latency: exactly CHANNELS clocks from the acceptance edge to out_valid=1.
- Accumulator width: WIDTH+$clog2(CHANNELS)+1 internally, so it never wraps. ovf=1 if acc > 2^OUT_W-1 at completion.
- DONE: out_valid=1, while sum and ovf are held stable.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - out_ready=0: hold indefinitely (backpressure); sum and ovf do not change.
- in_ready is 1 only in IDLE. There is no overlap between transactions. in_data changes outside the acceptance edge are ignored.
- in_valid asserted during ACCUM or DONE has no effect. The bundle is taken at the next IDLE edge if in_valid is still high.
- out_ready asserted outside DONE is ignored.
- Reset mid-ACCUM or mid-DONE aborts immediately to the reset values. The partial sum is never presented.
- Zero operands: sum=0, ovf=0, same latency.
- All-ones operands with default OUT_W: sum = CHANNELS*(2^WIDTH-1), ovf=0.

Optional Feature:
Macro SEQ_SUM_SATURATE_EN.
- Defined: on overflow, sum = all ones (2^OUT_W-1).
- Undefined: sum = acc mod 2^OUT_W (wrap).
- ovf is reported identically in both builds. Latency and handshake are unchanged.

Decomposition:
- Package seq_sum_pkg: state_t enum (IDLE, ACCUM, DONE) and a clog2-based ACC_W helper function.
- One sub-module, seq_sum_fmt: combinational reduction of acc to OUT_W bits plus ovf. The wrap/saturate `ifdef lives only here.

Test Plan:
1. WIDTH=4, CHANNELS=2, OUT_W=5; in_data={4'hF,4'hF} accepted -> after 2 clocks out_valid=1, sum=30, ovf=0. Repeat the exhaustive 256-combination sweep against nibble-sum expectations.
2. WIDTH=4, CHANNELS=2, OUT_W=4; operands 9 and 8 -> ovf=1; sum=1 with the macro undefined, sum=15 with SEQ_SUM_SATURATE_EN.
3. WIDTH=8, CHANNELS=4, OUT_W=10; all operands 255 -> after exactly 4 clocks sum=1020, ovf=0. in_ready stays 0 from acceptance until after the out handshake.
4. Backpressure: hold out_ready=0 for 10 clocks in DONE while toggling in_valid/in_data -> sum and ovf stable, in_ready=0. Raising out_ready returns the block to IDLE on the next edge.
5. Reset: assert reset asynchronously (between edges) one cycle into ACCUM -> out_valid=0, sum=0, in_ready=1 immediately. The next transaction (3+4) yields 7 with normal latency.
6. Back-to-back: in_valid held high with new data -> the second bundle is accepted on the first IDLE edge after the out handshake. Results appear in order with no lost or duplicated transaction.
